// File: rtl/sel_bit_deserializer_pkg.sv
// Shared types and helpers for the selection-bit deserializer.
// The optional parity mode is enabled by SEL_BIT_DESERIALIZER_PARITY_EN.
package deserPkg;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_PARITY  = 2'd1,
    S_STALL   = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Even-parity check over a zero-extended word plus parity bit; 1 means error.
  function automatic logic parity_of(input logic [32:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/sel_bit_deserializer_collector.sv
// Bit collector: writes accepted bits LSB-first at the running count and
// flags the acceptance of the final data bit of a word.
module bitCollector
  import deserPkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_bit,
  input  logic             i_accept,
  input  logic             i_flush,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_word,
  output logic             o_last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    count_r;

  // Merged view of the collector including a bit accepted this cycle.
  always_comb begin
    o_word = shift_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_accept && (count_r == CW'(i))) begin
        o_word[i] = i_bit;
      end else begin
        o_word[i] = shift_r[i];
      end
    end
  end

  assign o_last = i_accept && (count_r == CW'(WIDTH - 1));

  // Shift register and bit count; count parks at WIDTH until cleared.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      shift_r <= '0;
      count_r <= '0;
    end else begin
      if (i_accept) begin
        shift_r <= o_word;
      end
      if (i_clear || i_flush) begin
        count_r <= '0;
      end else if (i_accept) begin
        count_r <= count_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sel_bit_deserializer.sv
// Packs decision-tree selection bits into WIDTH-bit words on a valid/ready port.
// Define SEL_BIT_DESERIALIZER_PARITY_EN to expect an even-parity bit after each word.
module sel_bit_deserializer
  import deserPkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_bit,
  input  logic             i_bitValid,
  input  logic             i_flush,
  input  logic             i_clrOverflow,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_overflow,
  output logic             o_parityErr
);

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] word_s;
  logic             last_s;
  logic             accept_s;
  logic             drain_s;
  logic             can_load_s;
  logic             word_done_s;
  logic             load_s;
  logic             drop_s;
  logic             coll_flush_s;
  logic             perr_s;

  assign accept_s     = i_bitValid && !i_flush && (state_r == S_COLLECT);
  assign drain_s      = o_valid && i_ready;
  assign can_load_s   = !o_valid || drain_s;
  assign drop_s       = i_bitValid && (state_r == S_STALL);
  assign coll_flush_s = i_flush && (state_r != S_STALL);
  assign load_s       = (word_done_s && can_load_s) || ((state_r == S_STALL) && drain_s);

`ifdef SEL_BIT_DESERIALIZER_PARITY_EN
  logic par_accept_s;
  logic par_r;

  assign par_accept_s = i_bitValid && !i_flush && (state_r == S_PARITY);
  assign word_done_s  = par_accept_s;
  assign perr_s       = (state_r == S_STALL) ? parity_of(33'({word_s, par_r}))
                                             : parity_of(33'({word_s, i_bit}));

  // Parity bit is kept so a stalled word still reports its own check.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      par_r <= 1'b0;
    end else if (par_accept_s) begin
      par_r <= i_bit;
    end
  end
`else
  assign word_done_s = last_s;
  assign perr_s      = 1'b0;
`endif

  bitCollector #(.WIDTH(WIDTH)) u_collector (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_bit    (i_bit),
    .i_accept (accept_s),
    .i_flush  (coll_flush_s),
    .i_clear  (load_s),
    .o_word   (word_s),
    .o_last   (last_s)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_r <= S_COLLECT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a completed word stalls only when the output is occupied.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_COLLECT: begin
        if (i_flush) begin
          next_state_s = S_COLLECT;
        end else if (last_s) begin
`ifdef SEL_BIT_DESERIALIZER_PARITY_EN
          next_state_s = S_PARITY;
`else
          next_state_s = can_load_s ? S_COLLECT : S_STALL;
`endif
        end else begin
          next_state_s = S_COLLECT;
        end
      end
`ifdef SEL_BIT_DESERIALIZER_PARITY_EN
      S_PARITY: begin
        if (i_flush) begin
          next_state_s = S_COLLECT;
        end else if (par_accept_s) begin
          next_state_s = can_load_s ? S_COLLECT : S_STALL;
        end else begin
          next_state_s = S_PARITY;
        end
      end
`endif
      S_STALL: begin
        if (drain_s) begin
          next_state_s = S_COLLECT;
        end else begin
          next_state_s = S_STALL;
        end
      end
      default: begin
        next_state_s = S_COLLECT;
      end
    endcase
  end

  // Output register and handshake.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_parityErr <= 1'b0;
    end else if (load_s) begin
      o_data      <= word_s;
      o_valid     <= 1'b1;
      o_parityErr <= perr_s;
    end else if (drain_s) begin
      o_valid     <= 1'b0;
      o_parityErr <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle beats a clear.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_overflow <= 1'b0;
    end else if (drop_s) begin
      o_overflow <= 1'b1;
    end else if (i_clrOverflow) begin
      o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sel_bit_deserializer.sv
// Directed self-checking bench for sel_bit_deserializer (WIDTH=8).
module tb_sel_bit_deserializer;
  import deserPkg::*;

`ifdef SEL_BIT_DESERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       i_clk = 1'b0;
  logic       i_arst_n = 1'b0;
  logic       i_bit = 1'b0;
  logic       i_bitValid = 1'b0;
  logic       i_flush = 1'b0;
  logic       i_clrOverflow = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_overflow;
  logic       o_parityErr;

  int checks = 0;
  int failures = 0;

  sel_bit_deserializer #(.WIDTH(8)) dut (
    .i_clk         (i_clk),
    .i_arst_n      (i_arst_n),
    .i_bit         (i_bit),
    .i_bitValid    (i_bitValid),
    .i_flush       (i_flush),
    .i_clrOverflow (i_clrOverflow),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_overflow    (o_overflow),
    .o_parityErr   (o_parityErr)
  );

  always #5 i_clk = ~i_clk;

  // Bit i of the serial stream for word w; index 8 is the parity bit.
  function automatic logic word_bit(input logic [7:0] w, input int i, input logic par_ok);
    if (i < 8) return w[i];
    return (^w) ^ !par_ok;
  endfunction

  task automatic send_bit(input logic b);
    i_bit      = b;
    i_bitValid = 1'b1;
    @(negedge i_clk);
    i_bitValid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic par_ok, output logic early);
    early = 1'b0;
    for (int i = 0; i < NB; i++) begin
      send_bit(word_bit(w, i, par_ok));
      if (i < NB - 1 && o_valid === 1'b1) early = 1'b1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (o_data !== 8'h00 || o_valid !== 1'b0 || o_overflow !== 1'b0 || o_parityErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got data=%h valid=%b ovf=%b perr=%b exp 00/0/0/0",
               o_data, o_valid, o_overflow, o_parityErr);
    end
    @(negedge i_clk);
    i_arst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_basic();
    logic early;
    i_ready = 1'b1;
    send_word(8'h4D, 1'b1, early);
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL basic_early got=%b exp=0", early);
    end
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h4D) begin
      failures++;
      $display("FAIL basic_word got valid=%b data=%h exp 1/4d", o_valid, o_data);
    end
    checks++;
    if (o_parityErr !== 1'b0) begin
      failures++;
      $display("FAIL basic_perr got=%b exp=0", o_parityErr);
    end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_one_cycle got valid=%b exp=0", o_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic early;
    i_ready = 1'b0;
    send_word(8'h96, 1'b1, early);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h96) begin
      failures++;
      $display("FAIL b2b_first got valid=%b data=%h exp 1/96", o_valid, o_data);
    end
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1) i_ready = 1'b1;
      send_bit(word_bit(8'h69, i, 1'b1));
    end
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h69) begin
      failures++;
      $display("FAIL b2b_replace got valid=%b data=%h exp 1/69", o_valid, o_data);
    end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got valid=%b exp=0", o_valid);
    end
  endtask

  task automatic test_stall_overflow();
    logic early;
    i_ready = 1'b0;
    send_word(8'hA5, 1'b1, early);
    send_word(8'h3C, 1'b1, early);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'hA5 || dut.state_r !== S_STALL || o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold got valid=%b data=%h stall=%b ovf=%b exp 1/a5/1/0",
               o_valid, o_data, dut.state_r == S_STALL, o_overflow);
    end
    send_bit(1'b1);
    checks++;
    if (o_overflow !== 1'b1 || o_data !== 8'hA5) begin
      failures++;
      $display("FAIL stall_drop got ovf=%b data=%h exp 1/a5", o_overflow, o_data);
    end
    i_clrOverflow = 1'b1;
    send_bit(1'b0);
    checks++;
    if (o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drop_wins got=%b exp=1", o_overflow);
    end
    @(negedge i_clk);
    i_clrOverflow = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", o_overflow);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C || dut.state_r !== S_COLLECT) begin
      failures++;
      $display("FAIL stall_release got valid=%b data=%h collect=%b exp 1/3c/1",
               o_valid, o_data, dut.state_r == S_COLLECT);
    end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain got valid=%b exp=0", o_valid);
    end
  endtask

  task automatic test_flush();
    logic early;
    i_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i_flush = 1'b1;
    send_bit(1'b0);
    i_flush = 1'b0;
    send_word(8'hFF, 1'b1, early);
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL flush_early got=%b exp=0", early);
    end
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'hFF) begin
      failures++;
      $display("FAIL flush_word got valid=%b data=%h exp 1/ff", o_valid, o_data);
    end
    @(negedge i_clk);
  endtask

  task automatic test_async_reset();
    logic early;
    i_ready = 1'b0;
    send_word(8'h5A, 1'b1, early);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h5A) begin
      failures++;
      $display("FAIL arst_pre got valid=%b data=%h exp 1/5a", o_valid, o_data);
    end
    #1 i_arst_n = 1'b0;
    #1;
    checks++;
    if (o_data !== 8'h00 || o_valid !== 1'b0 || o_overflow !== 1'b0 || o_parityErr !== 1'b0) begin
      failures++;
      $display("FAIL arst_async got data=%h valid=%b ovf=%b perr=%b exp 00/0/0/0",
               o_data, o_valid, o_overflow, o_parityErr);
    end
    @(negedge i_clk);
    i_arst_n = 1'b1;
    i_ready  = 1'b1;
    send_word(8'hC3, 1'b1, early);
    checks++;
    if (early !== 1'b0 || o_valid !== 1'b1 || o_data !== 8'hC3) begin
      failures++;
      $display("FAIL arst_next got early=%b valid=%b data=%h exp 0/1/c3", early, o_valid, o_data);
    end
    @(negedge i_clk);
  endtask

`ifdef SEL_BIT_DESERIALIZER_PARITY_EN
  task automatic test_parity();
    logic early;
    i_ready = 1'b1;
    send_word(8'h01, 1'b0, early);
    checks++;
    if (o_valid !== 1'b1 || o_parityErr !== 1'b1) begin
      failures++;
      $display("FAIL parity_bad got valid=%b perr=%b exp 1/1", o_valid, o_parityErr);
    end
    send_word(8'h01, 1'b1, early);
    checks++;
    if (o_valid !== 1'b1 || o_parityErr !== 1'b0) begin
      failures++;
      $display("FAIL parity_good got valid=%b perr=%b exp 1/0", o_valid, o_parityErr);
    end
    @(negedge i_clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall_overflow();
    test_flush();
    test_async_reset();
`ifdef SEL_BIT_DESERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sel_bit_deserializer.md
# sel_bit_deserializer

Downstream consumer of the priority decision-tree stage. It takes the registered single-bit selection result, plus a qualifying valid, and packs successive bits LSB-first into WIDTH-bit words. Each completed word is presented on a valid/ready output port. The upstream stage has no backpressure, so the block holds at most one word in its output register and one in its collector; excess bits are dropped and flagged.

## Interface
- WIDTH, 8: data bits per word; legal range 2..32.
- i_clk  input  1  clock; all state updates on rising edge.
- i_arst_n  input  1  reset, asynchronous assert, active-low; all state cleared while low.
- i_bit  input  1  selected bit from the decision-tree output register.
- i_bitValid  input  1  i_bit is meaningful this cycle; the upstream "any ctrl set" condition, registered in step with i_bit.
- i_flush  input  1  discard the partial word in the collector.
- i_clrOverflow  input  1  clear the sticky overflow flag.
- o_data  output  WIDTH  completed word; bit 0 is the first bit received.
- o_valid  output  1  o_data holds an unconsumed word.
- i_ready  input  1  consumer accepts o_data when o_valid && i_ready at a rising edge.
- o_overflow  output  1  sticky; set when a valid bit is dropped.
- o_parityErr  output  1  parity flag qualified by o_valid; tied 0 without the macro.

## Operation
- Collector: a WIDTH-bit shift register plus a bit counter of width $clog2(WIDTH+1).
  - An accepted bit is written at position count, then count increments.
- FSM states: S_COLLECT, S_PARITY (macro only), S_STALL.
- S_COLLECT, on accepting bit WIDTH-1:
  - with macro: go to S_PARITY.
  - without macro: the word is complete.
- S_PARITY: the next accepted bit is the parity bit, and the word is complete.
- On word complete:
  - if the output register is empty, or is being drained this same edge (o_valid && i_ready), load it, set o_valid, reset count to 0 and return to S_COLLECT;
  - otherwise go to S_STALL, keeping the word in the collector.
- S_STALL:
  - when o_valid && i_ready, the collector word moves into the output register at that edge; o_valid stays 1 and the FSM returns to S_COLLECT with count 0;
  - any i_bitValid in S_STALL is dropped and sets o_overflow.
- i_flush:
  - in S_COLLECT or S_PARITY: count returns to 0 and the state to S_COLLECT; a bit presented the same cycle is discarded.
  - in S_STALL: no effect; a completed word is never flushed.
  - never affects the output register.
- Overflow precedence: i_clrOverflow clears o_overflow, but a drop in the same cycle wins and o_overflow reads 1.
- Reset values: o_data 0, o_valid 0, o_overflow 0, o_parityErr 0, count 0, state S_COLLECT. Reset mid-word discards all partial and held data.

## Timing
- Latency: the final bit (data or parity) accepted at edge N gives o_valid=1 and o_data stable after edge N.
- o_data and o_parityErr are held stable while o_valid && !i_ready.
- Sustained throughput: one word per WIDTH cycles (WIDTH+1 with macro) at 100% i_bitValid with i_ready held high; no bubbles inserted.
- Back-to-back: a new word completing on the same edge as the handshake replaces o_data, and o_valid stays 1.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- Macro: SEL_BIT_DESERIALIZER_PARITY_EN.
- Defined:
  - an even-parity bit follows each WIDTH data bits;
  - o_parityErr = ^{data, parityBit}, registered alongside o_data;
  - the S_PARITY state exists.
- Undefined:
  - words are WIDTH bits with no parity;
  - S_PARITY is absent;
  - o_parityErr is constant 0.

## Structure
- Package deserPkg holds:
  - typedef enum state_t {S_COLLECT, S_PARITY, S_STALL};
  - localparam DEFAULT_WIDTH = 8.
- Sub-module bitCollector: shift register, count and word-complete strobe, with flush input and WIDTH parameter.
- The top level owns the FSM, the output register, the handshake and the overflow flag.

## Test plan
- WIDTH=8, no macro, i_ready=1: send bits 1,0,1,1,0,0,1,0 on consecutive cycles -> o_data=8'h4D, o_valid high for one cycle, one edge after the 8th bit.
- i_ready=0 throughout: send two full words 8'hA5 then 8'h3C, then one more valid bit.
  - -> o_data=8'hA5 and the FSM is in S_STALL;
  - -> the extra bit sets o_overflow.
  - Then raise i_ready for one cycle -> o_data=8'h3C, o_valid stays 1.
- Send 3 bits, assert i_flush, then send 8 bits of 8'hFF -> single word 8'hFF; the partial bits never appear.
- Assert i_arst_n low after 5 bits and with o_valid=1 -> all outputs 0 immediately and asynchronously; the next full word is captured correctly.
- Macro defined: send 8'h01 followed by parity 0 -> o_parityErr=1. Send 8'h01 followed by parity 1 -> o_parityErr=0.
- Same cycle: drop a bit and assert i_clrOverflow -> o_overflow=1. Next cycle: i_clrOverflow alone -> o_overflow=0.
